// File: rtl/lap_store.sv
// Lap register file for the stopwatch.
// Captures {hour,minute,second,m_sec} snapshots into a DEPTH-entry circular
// store on SAVE, replays them oldest-first on RETRIEVE, wipes them on CLEAR,
// and answers the control FSM through the registered busy handshake.
module lap_store #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             save,
    input  logic             retrieve,
    input  logic             clear,
    input  logic [17:0]      epoch,
    input  logic [9:0]       m_epoch,
    output logic             busy,
    output logic [17:0]      lap_epoch,
    output logic [9:0]       lap_m_epoch,
    output logic [CNT_W-1:0] lap_index,
    output logic             lap_valid,
    output logic [CNT_W-1:0] lap_count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_ADDR,
        S_RD_DATA,
        S_SWEEP
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic             r_save_q;
    logic             r_retrieve_q;
    logic             r_clear_q;
    logic             w_save_edge;
    logic             w_retrieve_edge;
    logic             w_clear_edge;

    logic [27:0]      r_mem [DEPTH];
    logic [27:0]      r_rdata;
    logic [27:0]      r_wdata;
    logic [PTR_W-1:0] r_raddr;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_base;
    logic [PTR_W-1:0] r_cursor;
    logic [PTR_W-1:0] r_sweep;
    logic [CNT_W-1:0] r_count;

    logic [17:0]      r_lap_epoch;
    logic [9:0]       r_lap_m_epoch;
    logic [CNT_W-1:0] r_lap_index;
    logic             r_lap_valid;

    logic             w_we;
    logic [PTR_W-1:0] w_waddr;
    logic [27:0]      w_wdata;
    logic             w_full;
    logic             w_sweep_last;
    logic             w_cursor_last;

    assign w_save_edge     = save & ~r_save_q;
    assign w_retrieve_edge = retrieve & ~r_retrieve_q;
    assign w_clear_edge    = clear & ~r_clear_q;

    assign w_full        = (r_count == CNT_W'(DEPTH));
    assign w_sweep_last  = (r_sweep == PTR_W'(DEPTH - 1));
    assign w_cursor_last = (CNT_W'(r_cursor) == r_count - CNT_W'(1));

    // Request level history for rising-edge detection (tracks levels even while busy)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_save_q     <= 1'b0;
            r_retrieve_q <= 1'b0;
            r_clear_q    <= 1'b0;
        end else begin
            r_save_q     <= save;
            r_retrieve_q <= retrieve;
            r_clear_q    <= clear;
        end
    end

    // Next-state selection; edges only count in IDLE, priority clear > save > retrieve
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_clear_edge)         w_next = S_SWEEP;
                else if (w_save_edge)     w_next = S_WRITE;
                else if (w_retrieve_edge) w_next = S_RD_ADDR;
            end
            S_WRITE:   w_next = S_IDLE;
            S_RD_ADDR: w_next = S_RD_DATA;
            S_RD_DATA: w_next = S_IDLE;
            S_SWEEP:   if (w_sweep_last) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Single write port: lap capture in WRITE, zero fill in SWEEP
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_wr_ptr;
        w_wdata = r_wdata;
        if (r_state == S_WRITE) begin
            w_we = 1'b1;
        end else if (r_state == S_SWEEP) begin
            w_we    = 1'b1;
            w_waddr = r_sweep;
            w_wdata = '0;
        end
    end

    // Lap storage with registered read; contents need no reset since count governs validity
    always_ff @(posedge clock) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
        r_rdata <= r_mem[r_raddr];
    end

    // State register, pointers, cursor and lap output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wdata       <= '0;
            r_raddr       <= '0;
            r_wr_ptr      <= '0;
            r_rd_base     <= '0;
            r_cursor      <= '0;
            r_sweep       <= '0;
            r_count       <= '0;
            r_lap_epoch   <= '0;
            r_lap_m_epoch <= '0;
            r_lap_index   <= '0;
            r_lap_valid   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_lap_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // epoch is captured in the edge cycle so later ticks do not leak in
                    if (w_next == S_WRITE)   r_wdata <= {epoch, m_epoch};
                    if (w_next == S_RD_ADDR) r_raddr <= r_rd_base + r_cursor;
                    if (w_next == S_SWEEP)   r_sweep <= '0;
                end
                S_WRITE: begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    r_cursor <= '0;
                    if (w_full) r_rd_base <= r_rd_base + PTR_W'(1);
                    else        r_count   <= r_count + CNT_W'(1);
                end
                S_RD_DATA: begin
                    if (r_count != '0) begin
                        r_lap_epoch   <= r_rdata[27:10];
                        r_lap_m_epoch <= r_rdata[9:0];
                        r_lap_index   <= CNT_W'(r_cursor) + CNT_W'(1);
                        r_lap_valid   <= 1'b1;
                        r_cursor      <= w_cursor_last ? '0 : r_cursor + PTR_W'(1);
                    end else begin
                        r_lap_index <= '0;
                    end
                end
                S_SWEEP: begin
                    r_sweep <= r_sweep + PTR_W'(1);
                    if (w_sweep_last) begin
                        r_count       <= '0;
                        r_wr_ptr      <= '0;
                        r_rd_base     <= '0;
                        r_cursor      <= '0;
                        r_lap_epoch   <= '0;
                        r_lap_m_epoch <= '0;
                        r_lap_index   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign lap_epoch   = r_lap_epoch;
    assign lap_m_epoch = r_lap_m_epoch;
    assign lap_index   = r_lap_index;
    assign lap_valid   = r_lap_valid;
    assign lap_count   = r_count;
    assign full        = w_full;
    assign empty       = (r_count == '0);

endmodule

// File: tb/tb_lap_store.sv
// Self-checking bench for lap_store: queue-based lap model plus scoreboard.
module tb_lap_store;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             save = 1'b0;
    logic             retrieve = 1'b0;
    logic             clear = 1'b0;
    logic [17:0]      epoch = '0;
    logic [9:0]       m_epoch = '0;
    logic             busy;
    logic [17:0]      lap_epoch;
    logic [9:0]       lap_m_epoch;
    logic [CNT_W-1:0] lap_index;
    logic             lap_valid;
    logic [CNT_W-1:0] lap_count;
    logic             full;
    logic             empty;

    lap_store #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .save(save), .retrieve(retrieve), .clear(clear),
        .epoch(epoch), .m_epoch(m_epoch), .busy(busy), .lap_epoch(lap_epoch),
        .lap_m_epoch(lap_m_epoch), .lap_index(lap_index), .lap_valid(lap_valid),
        .lap_count(lap_count), .full(full), .empty(empty)
    );

    always #10 clock = ~clock;

    typedef struct packed {
        logic [17:0]      e;
        logic [9:0]       m;
        logic [CNT_W-1:0] idx;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    logic [27:0] laps[$];
    int          cursor = 0;
    exp_t        mon_x;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: laps is the stored history oldest-first, cursor the replay position
    task automatic model_save(input logic [17:0] e, input logic [9:0] m);
        laps.push_back({e, m});
        if (laps.size() > DEPTH) void'(laps.pop_front());
        cursor = 0;
    endtask

    task automatic model_retrieve();
        exp_t x;
        if (laps.size() > 0) begin
            x.e   = laps[cursor][27:10];
            x.m   = laps[cursor][9:0];
            x.idx = CNT_W'(cursor + 1);
            exp_q.push_back(x);
            cursor = (cursor + 1) % laps.size();
        end
    endtask

    task automatic model_clear();
        laps.delete();
        cursor = 0;
    endtask

    // Monitor: every lap_valid pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (!reset && lap_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_lap_valid: got lap_index %0d expected no pulse", lap_index);
            end else begin
                mon_x = exp_q.pop_front();
                chk("lap_epoch", lap_epoch, mon_x.e);
                chk("lap_m_epoch", lap_m_epoch, mon_x.m);
                chk("lap_index", lap_index, mon_x.idx);
            end
        end
    end

    task automatic check_status(input string tag);
        chk({tag, "_count"}, lap_count, laps.size());
        chk({tag, "_full"}, full, laps.size() == DEPTH);
        chk({tag, "_empty"}, empty, laps.size() == 0);
    endtask

    // kind: 0 save, 1 retrieve, 2 clear, 3 save+clear in the same cycle
    task automatic issue(input int kind, input logic [17:0] e, input logic [9:0] m);
        int  exp_busy;
        int  nb;
        bit  had_laps;
        @(negedge clock);
        had_laps = (laps.size() > 0);
        epoch    = e;
        m_epoch  = m;
        case (kind)
            0: begin save = 1'b1; model_save(e, m); exp_busy = 1; end
            1: begin retrieve = 1'b1; model_retrieve(); exp_busy = 2; end
            2: begin clear = 1'b1; model_clear(); exp_busy = DEPTH; end
            default: begin save = 1'b1; clear = 1'b1; model_clear(); exp_busy = DEPTH; end
        endcase
        @(negedge clock);
        save     = 1'b0;
        retrieve = 1'b0;
        clear    = 1'b0;
        epoch    = 18'($urandom);
        m_epoch  = 10'($urandom_range(999, 0));
        nb = 0;
        while (busy && nb < 64) begin
            nb++;
            @(negedge clock);
        end
        chk("busy_cycles", nb, exp_busy);
        if (kind == 1) chk("lap_valid_timing", lap_valid, had_laps);
        if (kind >= 2) begin
            chk("clear_lap_index", lap_index, 0);
            chk("clear_lap_epoch", lap_epoch, 0);
        end
        check_status("post_op");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [17:0] e;
        logic [9:0]  m;
        int          r;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_lap_valid", lap_valid, 0);
        chk("rst_lap_index", lap_index, 0);
        check_status("rst");
        reset = 1'b0;

        // Basic save then retrieve
        issue(0, {6'd1, 6'd2, 6'd3}, 10'd456);
        issue(1, 18'($urandom), 10'd0);

        // Oldest-first replay with wrap
        issue(2, '0, '0);
        for (int unsigned i = 0; i < 3; i++) issue(0, 18'($urandom), 10'($urandom_range(999, 0)));
        for (int unsigned i = 0; i < 4; i++) issue(1, '0, '0);

        // Overflow by one: oldest overwritten
        issue(2, '0, '0);
        for (int unsigned i = 0; i < DEPTH + 1; i++) issue(0, 18'($urandom), 10'($urandom_range(999, 0)));
        issue(1, '0, '0);

        // Held save stores once; retrieve raised while busy is dropped
        issue(2, '0, '0);
        e = 18'($urandom);
        m = 10'($urandom_range(999, 0));
        @(negedge clock);
        save = 1'b1; epoch = e; m_epoch = m;
        model_save(e, m);
        @(negedge clock);
        epoch = 18'($urandom);
        retrieve = 1'b1;
        chk("hold_busy_n1", busy, 1);
        @(negedge clock);
        chk("hold_busy_n2", busy, 0);
        repeat (3) @(negedge clock);
        retrieve = 1'b0;
        repeat (15) @(negedge clock);
        save = 1'b0;
        @(negedge clock);
        chk("hold_busy_end", busy, 0);
        check_status("hold");
        issue(1, '0, '0);

        // Simultaneous save+clear, then retrieve on empty
        issue(0, 18'($urandom), 10'd1);
        issue(3, 18'($urandom), 10'd2);
        issue(1, '0, '0);

        // Reset during RD_DATA
        issue(0, 18'($urandom), 10'd77);
        @(negedge clock);
        retrieve = 1'b1;
        @(negedge clock);
        retrieve = 1'b0;
        @(negedge clock);
        chk("rd_data_busy_before_reset", busy, 1);
        reset = 1'b1;
        model_clear();
        @(negedge clock);
        chk("rst_rd_busy", busy, 0);
        chk("rst_rd_count", lap_count, 0);
        chk("rst_rd_lap_valid", lap_valid, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_rd_lap_valid_after", lap_valid, 0);

        // Reset during SWEEP
        issue(0, 18'($urandom), 10'd5);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        repeat (2) @(negedge clock);
        chk("sweep_busy_before_reset", busy, 1);
        reset = 1'b1;
        model_clear();
        @(negedge clock);
        chk("rst_sw_busy", busy, 0);
        chk("rst_sw_count", lap_count, 0);
        chk("rst_sw_lap_valid", lap_valid, 0);
        reset = 1'b0;

        // Randomized traffic
        for (int unsigned i = 0; i < 300; i++) begin
            r = int'($urandom_range(99, 0));
            e = 18'($urandom);
            m = 10'($urandom_range(999, 0));
            if (r < 45)      issue(0, e, m);
            else if (r < 90) issue(1, e, m);
            else if (r < 97) issue(2, e, m);
            else             issue(3, e, m);
        end

        repeat (4) @(negedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
